// File: rtl/alu_logic_pkg.sv
// Shared definitions for the RV32 bitwise-logic unit: op encoding and the
// combinational evaluator used by both the pipelined and single-cycle paths.
package alu_logic_pkg;

  typedef enum logic [2:0] {
    LOP_AND  = 3'b000,
    LOP_OR   = 3'b001,
    LOP_XOR  = 3'b010,
    LOP_ANDN = 3'b011,
    LOP_ORN  = 3'b100,
    LOP_XNOR = 3'b101,
    LOP_ORCB = 3'b110,
    LOP_RSVD = 3'b111
  } logic_op_e;

  // Widest datapath the evaluator serves; narrower callers zero-extend and truncate.
  localparam int LOGIC_MAX_W = 128;

  function automatic logic [LOGIC_MAX_W-1:0] logic_eval(
    input logic_op_e                op,
    input logic [LOGIC_MAX_W-1:0]   a,
    input logic [LOGIC_MAX_W-1:0]   b
  );
    logic [LOGIC_MAX_W-1:0] y;
    y = '0;
    case (op)
      LOP_AND:  y = a & b;
      LOP_OR:   y = a | b;
      LOP_XOR:  y = a ^ b;
      LOP_ANDN: y = a & ~b;
      LOP_ORN:  y = a | ~b;
      LOP_XNOR: y = ~(a ^ b);
      LOP_ORCB: begin
        for (int i = 0; i < LOGIC_MAX_W / 8; i++) begin
          y[8*i +: 8] = {8{|a[8*i +: 8]}};
        end
      end
      default:  y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/alu_logic_pipe_if.sv
// Valid/ready operand and result bus of the bitwise-logic pipeline.
interface alu_logic_pipe_if
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic_op_e        in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_illegal, out_tag
  );
endinterface

// File: rtl/alu_logic_stage.sv
// One elastic register stage: holds valid + payload, accepts when empty or
// when the downstream side is taking the current entry this cycle.
module alu_logic_stage #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_vld,
  output logic                 up_rdy,
  input  logic [PAYLOAD_W-1:0] up_data,
  output logic                 dn_vld,
  input  logic                 dn_rdy,
  output logic [PAYLOAD_W-1:0] dn_data
);
  logic                 vld_p0;
  logic [PAYLOAD_W-1:0] data_p0;
  logic                 load;

  // An empty stage always loads, so bubbles collapse without waiting on dn_rdy.
  assign load   = !vld_p0 || dn_rdy;
  assign up_rdy = load;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (load) begin
      vld_p0 <= up_vld;
      if (up_vld) data_p0 <= up_data;
    end
  end

  assign dn_vld  = vld_p0;
  assign dn_data = data_p0;
endmodule

// File: rtl/alu_logic_pipe.sv
// Pipelined RV32 bitwise-logic unit: combinational evaluation feeding a chain
// of PIPE_STAGES elastic register stages with valid/ready backpressure.
module alu_logic_pipe
  import alu_logic_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  alu_logic_pipe_if.slave  bus
);
  localparam int PAYLOAD_W = WIDTH + 2 + TAG_W;

  if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > LOGIC_MAX_W) begin : g_bad_width
    $error("alu_logic_pipe: WIDTH must be a multiple of 8 in 8..%0d", LOGIC_MAX_W);
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("alu_logic_pipe: PIPE_STAGES must be in 1..4");
  end

  logic [LOGIC_MAX_W-1:0] y_full;
  logic [WIDTH-1:0]       y_c;
  logic                   zero_c;
  logic                   illegal_c;
  logic [PAYLOAD_W-1:0]   payload_c;
  logic                   unused_y;

  always_comb begin
    y_full    = logic_eval(bus.in_op, LOGIC_MAX_W'(bus.in_a), LOGIC_MAX_W'(bus.in_b));
    y_c       = y_full[WIDTH-1:0];
    zero_c    = (y_c == '0);
    illegal_c = (bus.in_op == LOP_RSVD);
    payload_c = {y_c, zero_c, illegal_c, bus.in_tag};
  end

  assign unused_y = ^y_full;

  // Stage k feeds stage k+1; ready ripples back from out_ready to in_ready.
  for (genvar k = 0; k < PIPE_STAGES; k++) begin : stg
    logic                 up_vld;
    logic                 up_rdy;
    logic [PAYLOAD_W-1:0] up_data;
    logic                 dn_vld;
    logic                 dn_rdy;
    logic [PAYLOAD_W-1:0] dn_data;

    if (k == 0) begin : g_head
      assign up_vld  = bus.in_valid;
      assign up_data = payload_c;
    end else begin : g_link
      assign up_vld  = stg[k-1].dn_vld;
      assign up_data = stg[k-1].dn_data;
    end

    if (k == PIPE_STAGES - 1) begin : g_tail
      assign dn_rdy = bus.out_ready;
    end else begin : g_next
      assign dn_rdy = stg[k+1].up_rdy;
    end

    alu_logic_stage #(.PAYLOAD_W(PAYLOAD_W)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .up_vld  (up_vld),
      .up_rdy  (up_rdy),
      .up_data (up_data),
      .dn_vld  (dn_vld),
      .dn_rdy  (dn_rdy),
      .dn_data (dn_data)
    );
  end

  assign bus.in_ready  = stg[0].up_rdy;
  assign bus.out_valid = stg[PIPE_STAGES-1].dn_vld;
  assign {bus.out_y, bus.out_zero, bus.out_illegal, bus.out_tag} = stg[PIPE_STAGES-1].dn_data;
endmodule

// File: tb/tb_alu_logic_pipe.sv
// Self-checking bench: directed steps plus a randomized scoreboard over three
// configurations (32b/2 stages, 64b/4 stages, 64b/1 stage).
module tb_alu_logic_pipe;
  import alu_logic_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_logic_pipe_if #(.WIDTH(32), .TAG_W(5)) ia ();
  alu_logic_pipe_if #(.WIDTH(64), .TAG_W(5)) ib ();
  alu_logic_pipe_if #(.WIDTH(64), .TAG_W(5)) ic ();

  alu_logic_pipe #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(5)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  alu_logic_pipe #(.WIDTH(64), .PIPE_STAGES(4), .TAG_W(5)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  alu_logic_pipe #(.WIDTH(64), .PIPE_STAGES(1), .TAG_W(5)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  typedef struct packed {
    logic [63:0] y;
    logic        zero;
    logic        illegal;
    logic [4:0]  tag;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   fires_a = 0;
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec, ga, gb, gc;

  task automatic chk(input string name, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Reference behaviour written straight from the op table.
  function automatic exp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [4:0] tag, input int w);
    exp_t        r;
    logic [63:0] mask;
    logic [63:0] y;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    case (op)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: y = a ^ b;
      3'd3: y = a & ~b;
      3'd4: y = a | ~b;
      3'd5: y = ~(a ^ b);
      3'd6: begin
        y = 64'd0;
        for (int i = 0; i < 8; i++) y[8*i +: 8] = (a[8*i +: 8] != 8'd0) ? 8'hFF : 8'h00;
      end
      default: y = 64'd0;
    endcase
    r.y       = y & mask;
    r.zero    = (r.y == 64'd0);
    r.illegal = (op == 3'd7);
    r.tag     = tag;
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) if ($urandom_range(0, 3) == 0) v[8*i +: 8] = 8'h00;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      qa.delete(); qb.delete(); qc.delete();
    end else begin
      if (ia.out_valid && ia.out_ready) begin
        fires_a++;
        ga = '{y: 64'(ia.out_y), zero: ia.out_zero, illegal: ia.out_illegal, tag: ia.out_tag};
        if (qa.size() == 0) chk("a_spurious_out", 80'(qa.size()), 80'd1);
        else begin ea = qa.pop_front(); chk("a_result", 80'(ga), 80'(ea)); end
      end
      if (ib.out_valid && ib.out_ready) begin
        gb = '{y: ib.out_y, zero: ib.out_zero, illegal: ib.out_illegal, tag: ib.out_tag};
        if (qb.size() == 0) chk("b_spurious_out", 80'(qb.size()), 80'd1);
        else begin eb = qb.pop_front(); chk("b_result", 80'(gb), 80'(eb)); end
      end
      if (ic.out_valid && ic.out_ready) begin
        gc = '{y: ic.out_y, zero: ic.out_zero, illegal: ic.out_illegal, tag: ic.out_tag};
        if (qc.size() == 0) chk("c_spurious_out", 80'(qc.size()), 80'd1);
        else begin ec = qc.pop_front(); chk("c_result", 80'(gc), 80'(ec)); end
      end
      if (ia.in_valid && ia.in_ready) qa.push_back(model(ia.in_op, 64'(ia.in_a), 64'(ia.in_b), ia.in_tag, 32));
      if (ib.in_valid && ib.in_ready) qb.push_back(model(ib.in_op, ib.in_a, ib.in_b, ib.in_tag, 64));
      if (ic.in_valid && ic.in_ready) qc.push_back(model(ic.in_op, ic.in_a, ic.in_b, ic.in_tag, 64));
    end
  end

  task automatic send_a(input string name, input logic_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] ey, input logic ez, input logic ei);
    int lat;
    ia.in_valid = 1'b1; ia.in_op = op; ia.in_a = a; ia.in_b = b; ia.in_tag = tag;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    lat = 1;
    while (!ia.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 80'(lat), 80'd2);
    chk({name, "_y"}, 80'(ia.out_y), 80'(ey));
    chk({name, "_zero"}, 80'(ia.out_zero), 80'(ez));
    chk({name, "_illegal"}, 80'(ia.out_illegal), 80'(ei));
    chk({name, "_tag"}, 80'(ia.out_tag), 80'(tag));
  endtask

  initial begin
    logic [31:0] sa[6];
    logic [31:0] sb[6];
    logic [31:0] held_y;
    logic [4:0]  held_tag;
    int          idx;
    int          f0;
    int          la, lb, lc;

    rst = 1'b1;
    ia.in_valid = 1'b0; ia.in_op = LOP_AND; ia.in_a = '0; ia.in_b = '0; ia.in_tag = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_op = LOP_AND; ib.in_a = '0; ib.in_b = '0; ib.in_tag = '0; ib.out_ready = 1'b1;
    ic.in_valid = 1'b0; ic.in_op = LOP_AND; ic.in_a = '0; ic.in_b = '0; ic.in_tag = '0; ic.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 80'(ia.out_valid), 80'd0);
    chk("rst_out_y", 80'(ia.out_y), 80'd0);
    chk("rst_out_zero", 80'(ia.out_zero), 80'd0);
    chk("rst_out_illegal", 80'(ia.out_illegal), 80'd0);
    chk("rst_out_tag", 80'(ia.out_tag), 80'd0);
    chk("rst_b_out_valid", 80'(ib.out_valid), 80'd0);
    rst = 1'b0;
    chk("rst_in_ready", 80'(ia.in_ready), 80'd1);

    send_a("or",   LOP_OR,   32'hF0F0_0000, 32'h0000_0F0F, 5'd3, 32'hF0F0_0F0F, 1'b0, 1'b0);
    send_a("orcb", LOP_ORCB, 32'h0100_8000, 32'h1234_5678, 5'd4, 32'hFF00_FF00, 1'b0, 1'b0);
    send_a("andn", LOP_ANDN, 32'hFFFF_FFFF, 32'hFFFF_0000, 5'd5, 32'h0000_FFFF, 1'b0, 1'b0);
    send_a("xor",  LOP_XOR,  32'h1234_5678, 32'h1234_5678, 5'd6, 32'h0000_0000, 1'b1, 1'b0);
    send_a("rsvd", LOP_RSVD, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd7, 32'h0000_0000, 1'b1, 1'b1);
    send_a("xnor", LOP_XNOR, 32'h0F0F_0F0F, 32'h00FF_00FF, 5'd8, 32'hF00F_F00F, 1'b0, 1'b0);

    // Six back-to-back ops with the consumer stalled for cycles 3..7.
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      sa[k] = $urandom;
      sb[k] = $urandom;
    end
    f0 = fires_a;
    idx = 0;
    held_y = '0;
    held_tag = '0;
    for (int c = 0; c < 16; c++) begin
      ia.out_ready = !(c >= 3 && c <= 7);
      ia.in_valid  = (idx < 6);
      if (idx < 6) begin
        ia.in_op  = logic_op_e'(3'((idx * 3 + 1) % 8));
        ia.in_a   = sa[idx];
        ia.in_b   = sb[idx];
        ia.in_tag = 5'(idx);
      end
      #3;
      if (c <= 9) chk("stall_in_ready", 80'(ia.in_ready), 80'(!(c >= 3 && c <= 7)));
      if (c == 3) begin
        held_y = ia.out_y;
        held_tag = ia.out_tag;
        chk("stall_head_tag", 80'(ia.out_tag), 80'd1);
      end
      if (c >= 3 && c <= 7) begin
        chk("stall_valid", 80'(ia.out_valid), 80'd1);
        chk("stall_hold_y", 80'(ia.out_y), 80'(held_y));
        chk("stall_hold_tag", 80'(ia.out_tag), 80'(held_tag));
      end
      if (ia.in_valid && ia.in_ready) idx++;
      @(posedge clk); #1;
    end
    chk("stall_accepted", 80'(idx), 80'd6);
    chk("stall_emitted", 80'(fires_a - f0), 80'd6);
    chk("stall_drained", 80'(qa.size()), 80'd0);

    // Reset with two ops in flight; a fresh op must come back alone.
    ia.out_ready = 1'b1;
    ia.in_valid = 1'b1; ia.in_op = LOP_OR; ia.in_a = 32'h1111_0000; ia.in_b = 32'h0000_2222; ia.in_tag = 5'd10;
    @(posedge clk); #1;
    ia.in_op = LOP_AND; ia.in_a = 32'hFFFF_FFFF; ia.in_b = 32'h8765_4321; ia.in_tag = 5'd11;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    ia.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ia.out_ready = 1'b1;
    chk("midrst_out_valid", 80'(ia.out_valid), 80'd0);
    chk("midrst_out_y", 80'(ia.out_y), 80'd0);
    chk("midrst_out_tag", 80'(ia.out_tag), 80'd0);
    chk("midrst_in_ready", 80'(ia.in_ready), 80'd1);
    f0 = fires_a;
    send_a("postrst", LOP_ORN, 32'h0000_00F0, 32'hFFFF_FF00, 5'd12, 32'h0000_00FF, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("postrst_alone", 80'(fires_a - f0), 80'd1);

    // Latency of each configuration from a single handshake.
    ia.in_valid = 1'b1; ia.in_op = LOP_OR; ia.in_a = 32'hF0F0_0000; ia.in_b = 32'h0000_0F0F; ia.in_tag = 5'd3;
    ib.in_valid = 1'b1; ib.in_op = LOP_OR; ib.in_a = 64'hF0F0_0000_0000_0000; ib.in_b = 64'h0000_0F0F_0000_0001; ib.in_tag = 5'd3;
    ic.in_valid = 1'b1; ic.in_op = LOP_ORCB; ic.in_a = 64'h0100_8000_0000_0001; ic.in_b = 64'd0; ic.in_tag = 5'd9;
    @(posedge clk); #1;
    ia.in_valid = 1'b0; ib.in_valid = 1'b0; ic.in_valid = 1'b0;
    la = 0; lb = 0; lc = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (ia.out_valid && la == 0) la = cyc;
      if (ib.out_valid && lb == 0) begin
        lb = cyc;
        chk("b64_or_y", 80'(ib.out_y), 80'h0000_F0F0_0F0F_0000_0001);
      end
      if (ic.out_valid && lc == 0) begin
        lc = cyc;
        chk("c64_orcb_y", 80'(ic.out_y), 80'h0000_FF00_FF00_0000_00FF);
      end
      @(posedge clk); #1;
    end
    chk("lat_w32_s2", 80'(la), 80'd2);
    chk("lat_w64_s4", 80'(lb), 80'd4);
    chk("lat_w64_s1", 80'(lc), 80'd1);

    // Randomized traffic with random backpressure on all three units.
    for (int c = 0; c < 15000; c++) begin
      ia.in_valid = ($urandom_range(0, 9) != 0);
      ia.in_op = logic_op_e'(3'($urandom_range(0, 7)));
      ia.in_a = 32'(rnd64()); ia.in_b = 32'(rnd64()); ia.in_tag = 5'($urandom);
      ia.out_ready = ($urandom_range(0, 5) != 0);
      ib.in_valid = ($urandom_range(0, 9) != 0);
      ib.in_op = logic_op_e'(3'($urandom_range(0, 7)));
      ib.in_a = rnd64(); ib.in_b = rnd64(); ib.in_tag = 5'($urandom);
      ib.out_ready = ($urandom_range(0, 5) != 0);
      ic.in_valid = ($urandom_range(0, 9) != 0);
      ic.in_op = logic_op_e'(3'($urandom_range(0, 7)));
      ic.in_a = rnd64(); ic.in_b = rnd64(); ic.in_tag = 5'($urandom);
      ic.out_ready = ($urandom_range(0, 5) != 0);
      @(posedge clk); #1;
    end
    ia.in_valid = 1'b0; ib.in_valid = 1'b0; ic.in_valid = 1'b0;
    ia.out_ready = 1'b1; ib.out_ready = 1'b1; ic.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rand_a_drained", 80'(qa.size()), 80'd0);
    chk("rand_b_drained", 80'(qb.size()), 80'd0);
    chk("rand_c_drained", 80'(qc.size()), 80'd0);
    chk("rand_a_idle", 80'(ia.out_valid), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
